regfile_wr_arbiter: RTL and testbench
=====================================

# regfile_wr_arbiter

Round-robin arbiter that shares the single write port of the register file among several requesters. It drives the one-hot `in_en` lines and the common `d` bus of the `dffe` register bank. Each granted write is committed in exactly one cycle. Writes to register 0 are acknowledged but suppressed. A freeze input stalls new grants without corrupting an in-flight write.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `NREG`, 32: number of registers in the bank.
- `AW`, 5: register address width, clog2(`NREG`).
- `DW`, 32: data width.

- `clk`  in  1  clock.
- `clr`  in  1  reset, asynchronous, active-high.
- `req`  in  `NREQ`  per-requester write request.
- `req_addr`  in  `NREQ*AW`  packed addresses; requester i at bits [i*AW +: AW].
- `req_data`  in  `NREQ*DW`  packed data; requester i at bits [i*DW +: DW].
- `freeze`  in  1  when high, no new grant is issued.
- `gnt`  out  `NREQ`  one-hot pulse: the requester's write is committed at the end of this cycle.
- `reg_in_en`  out  `NREG`  one-hot write enables to the bank; bit k drives `in_en` of register k.
- `reg_d`  out  `DW`  write data to all bank registers.
- `busy`  out  1  high while any `reg_in_en` bit is high.

## Operation
- Two states: IDLE (no grant in the current cycle) and ISSUE (exactly one `gnt` bit high).
- At each rising edge, the arbiter takes the set of eligible requesters:
  - `req[i]` is high, and `gnt[i]` is not high in the current cycle (the just-granted requester is masked for that edge), and
  - `freeze` is low.
- If the eligible set is non-empty:
  - Select the first eligible requester found by scanning upward from pointer `rr` with wrap-around at `NREQ`.
  - Register the winner's `gnt` bit, `reg_d` = its data, and `reg_in_en` = one-hot decode of its address.
  - Next state is ISSUE.
  - Set `rr` = winner+1 mod `NREQ`.
- If the eligible set is empty: next state is IDLE, all `gnt` and `reg_in_en` bits are 0, `reg_d` holds its last value, and `rr` is unchanged.
- Address 0: `gnt` pulses normally, `reg_in_en` stays all-zero, and `busy` stays low.
- Address >= `NREG`: treated like address 0 (acknowledged, no enable).
- Requester contract: hold `req`, address and data stable from assertion until the cycle `gnt` is seen high. After that, either drop `req` or present a new write. A `req` still high after `gnt` is a new request.
- `freeze` blocks only new arbitration. A grant already registered completes its cycle.
- Invariants: at most one `gnt` bit and at most one `reg_in_en` bit high in any cycle. `busy` = OR of `reg_in_en`.

## Timing
- Reset values while `clr` is high, applied asynchronously: `gnt`=0, `reg_in_en`=0, `reg_d`=0, `busy`=0, `rr`=0, state IDLE. `clr` also clears the register bank, so no partial write survives.
- `clr` asserted during ISSUE: the enable drops immediately and the pending write is lost. Requesters must re-request after `clr` falls.
- Latency: `req` sampled high at edge E gives `gnt` and `reg_in_en` high in the cycle E..E+1. The bank captures `reg_d` at edge E+1.
- Throughput: one write per cycle across different requesters. A single requester can be granted at most every other cycle, because of the gnt mask.
- Priority after reset: 0, 1, 2, 3, then rotating.
- `freeze` raised before edge E: no grant issues from E. Lowering it before edge F makes requests eligible at F.

## Test plan
- Single write: requester 2 requests addr 7 with data 0xDEADBEEF, all other `req` low.
  - Exactly one cycle later: `gnt`=0100 and `reg_in_en`[7]=1 for one cycle, `reg_d`=0xDEADBEEF.
  - Register 7 reads 0xDEADBEEF afterwards.
- Contention: all 4 requesters raise `req` together after reset, each with a distinct address and dropping `req` after its `gnt`.
  - Grants are 0, 1, 2, 3 on 4 consecutive cycles, with `busy` high throughout.
  - If the requesters re-raise immediately, the next round is again 0, 1, 2, 3.
- Zero register: requester 1 writes 0x1234 to addr 0.
  - `gnt`[1] pulses, `reg_in_en` stays 0 and `busy` stays 0.
  - Register 0 remains 0.
- Freeze: `freeze` is raised in the cycle `gnt`[0] is high while requesters 1 and 3 are pending.
  - The requester 0 write completes, then no grants while `freeze` is high.
  - One cycle after `freeze` falls, `gnt`[1] pulses; `gnt`[3] pulses in the next cycle.
- Same requester back-to-back: requester 0 holds `req` high continuously with no other requests.
  - `gnt`[0] pulses every other cycle (high, low, high, ...).
- Reset mid-write: `clr` is asserted midway through the cycle `reg_in_en`[5] is high.
  - All outputs go to 0 before the next edge and register 5 reads 0.
  - After `clr` falls, the first grant goes to the lowest-index requester.

Source files
------------

// File: rtl/regfile_wr_arbiter_if.sv
// Write-port bundle between the requesters and the register-file write arbiter.
// The master side is the requester/bank environment; the slave side is the arbiter.
interface regfile_wr_arbiter_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned NREG = 32,
  parameter int unsigned AW   = 5,
  parameter int unsigned DW   = 32
);
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic               freeze;
  logic [NREQ-1:0]    gnt;
  logic [NREG-1:0]    reg_in_en;
  logic [DW-1:0]      reg_d;
  logic               busy;

  modport master (
    output req, req_addr, req_data, freeze,
    input  gnt, reg_in_en, reg_d, busy
  );

  modport slave (
    input  req, req_addr, req_data, freeze,
    output gnt, reg_in_en, reg_d, busy
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the single register-file write port; one committed
// write per granted cycle, register 0 writes acknowledged but never enabled.
module regfile_wr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned NREG = 32,
  parameter int unsigned AW   = 5,
  parameter int unsigned DW   = 32
) (
  input  logic                 clk,
  input  logic                 clr,
  regfile_wr_arbiter_if.slave  bus
);

  localparam int unsigned RRW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t          state;
  logic [RRW-1:0]  rr;
  logic [NREQ-1:0] gnt_mask;
  logic [NREQ-1:0] elig;
  logic [RRW-1:0]  idx;
  logic [RRW-1:0]  win_idx;
  logic            win_found;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_data;
  logic [NREG-1:0] win_en;

  logic [AW-1:0]   addr_arr [NREQ];
  logic [DW-1:0]   data_arr [NREQ];

  // Unpack the flat request buses into per-requester fields.
  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign addr_arr[i] = bus.req_addr[i*AW +: AW];
    assign data_arr[i] = bus.req_data[i*DW +: DW];
  end

  // The requester granted in this cycle is not eligible at the coming edge.
  assign gnt_mask = (state == ISSUE) ? bus.gnt : '0;
  assign elig     = bus.req & ~gnt_mask & {NREQ{~bus.freeze}};

  // First eligible requester scanning upward from rr, wrapping at NREQ.
  always_comb begin
    idx       = '0;
    win_idx   = '0;
    win_found = 1'b0;
    for (int off = 0; off < NREQ; off++) begin
      idx = RRW'((32'(rr) + 32'(off)) % NREQ);
      if (!win_found && elig[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
  end

  // Address 0 and out-of-range addresses produce no enable.
  always_comb begin
    win_addr = addr_arr[win_idx];
    win_data = data_arr[win_idx];
    win_en   = '0;
    if ((win_addr != '0) && (32'(win_addr) < NREG)) begin
      win_en = NREG'(1) << win_addr;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state         <= IDLE;
      rr            <= '0;
      bus.gnt       <= '0;
      bus.reg_in_en <= '0;
      bus.reg_d     <= '0;
      bus.busy      <= 1'b0;
    end else if (win_found) begin
      state         <= ISSUE;
      rr            <= (win_idx == RRW'(NREQ - 1)) ? '0 : win_idx + RRW'(1);
      bus.gnt       <= NREQ'(1) << win_idx;
      bus.reg_in_en <= win_en;
      bus.reg_d     <= win_data;
      bus.busy      <= |win_en;
    end else begin
      // reg_d deliberately holds its last value when idle.
      state         <= IDLE;
      bus.gnt       <= '0;
      bus.reg_in_en <= '0;
      bus.busy      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter with a scoreboard of expected grants
// and a behavioural model of the dffe register bank driven by the arbiter.
module tb_regfile_wr_arbiter;
  localparam int unsigned NREQ = 4;
  localparam int unsigned NREG = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned DW   = 32;

  logic clk = 1'b0;
  logic clr;

  always #5 clk = ~clk;

  regfile_wr_arbiter_if #(.NREQ(NREQ), .NREG(NREG), .AW(AW), .DW(DW)) bus ();

  regfile_wr_arbiter #(.NREQ(NREQ), .NREG(NREG), .AW(AW), .DW(DW)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  // Register bank: cleared by clr, captures reg_d where its enable is high.
  logic [DW-1:0] bank [NREG];
  always @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int k = 0; k < NREG; k++) bank[k] <= '0;
    end else begin
      for (int k = 0; k < NREG; k++) if (bus.reg_in_en[k]) bank[k] <= bus.reg_d;
    end
  end

  typedef struct {
    int              cyc;
    logic [NREQ-1:0] gnt;
    logic [NREG-1:0] en;
    logic [DW-1:0]   d;
    logic            busy;
    string           tag;
  } exp_t;

  exp_t sbq[$];
  int   cyc;
  int   errors;
  int   checks;
  logic [NREQ-1:0] hold;
  logic [NREQ-1:0] rearm;
  logic [AW-1:0]   nxt_addr [NREQ];
  logic [DW-1:0]   nxt_data [NREQ];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int i, input logic v, input int addr, input logic [DW-1:0] d);
    bus.req[i]                = v;
    bus.req_addr[i*AW +: AW]  = AW'(addr);
    bus.req_data[i*DW +: DW]  = d;
  endtask

  task automatic expect_w(input int c, input int g, input int addr,
                          input logic [DW-1:0] d, input string tag);
    exp_t e;
    e.cyc  = c;
    e.gnt  = NREQ'(1) << g;
    e.busy = (addr != 0) && (addr < NREG);
    e.en   = e.busy ? (NREG'(1) << addr) : '0;
    e.d    = d;
    e.tag  = tag;
    sbq.push_back(e);
  endtask

  // Compare this cycle's outputs against the scoreboard.
  task automatic sample();
    exp_t e;
    if (bus.gnt != '0) begin
      if (sbq.size() == 0) begin
        chk("spurious_gnt", 64'(bus.gnt), 64'(0));
      end else begin
        e = sbq.pop_front();
        chk({e.tag, "_cyc"},  64'(cyc),           64'(e.cyc));
        chk({e.tag, "_gnt"},  64'(bus.gnt),       64'(e.gnt));
        chk({e.tag, "_en"},   64'(bus.reg_in_en), 64'(e.en));
        chk({e.tag, "_d"},    64'(bus.reg_d),     64'(e.d));
        chk({e.tag, "_busy"}, 64'(bus.busy),      64'(e.busy));
      end
    end else begin
      if (sbq.size() != 0 && sbq[0].cyc <= cyc) begin
        e = sbq.pop_front();
        chk({e.tag, "_missing"}, 64'(bus.gnt), 64'(e.gnt));
      end
      chk("idle_en",   64'(bus.reg_in_en), 64'(0));
      chk("idle_busy", 64'(bus.busy),      64'(0));
    end
  endtask

  // One clock: sample after the edge, then requesters react to their grant.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    sample();
    for (int i = 0; i < NREQ; i++) begin
      if (bus.gnt[i]) begin
        if (rearm[i]) begin
          drive(i, 1'b1, int'(nxt_addr[i]), nxt_data[i]);
          rearm[i] = 1'b0;
        end else if (!hold[i]) begin
          bus.req[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic do_reset();
    clr        = 1'b1;
    bus.req    = '0;
    bus.freeze = 1'b0;
    hold       = '0;
    rearm      = '0;
    #1;
    chk("rst_gnt",  64'(bus.gnt),       64'(0));
    chk("rst_en",   64'(bus.reg_in_en), 64'(0));
    chk("rst_d",    64'(bus.reg_d),     64'(0));
    chk("rst_busy", 64'(bus.busy),      64'(0));
    step();
    step();
    clr = 1'b0;
  endtask

  initial begin
    int c;
    errors       = 0;
    checks       = 0;
    cyc          = 0;
    bus.req      = '0;
    bus.req_addr = '0;
    bus.req_data = '0;
    bus.freeze   = 1'b0;
    hold         = '0;
    rearm        = '0;
    for (int i = 0; i < NREQ; i++) begin
      nxt_addr[i] = '0;
      nxt_data[i] = '0;
    end

    do_reset();

    // Single write from requester 2.
    drive(2, 1'b1, 7, 32'hDEADBEEF);
    expect_w(cyc + 1, 2, 7, 32'hDEADBEEF, "single");
    repeat (3) step();
    chk("bank7", 64'(bank[7]), 64'(32'hDEADBEEF));

    // Full contention, each requester re-raising once with a new write.
    do_reset();
    c = cyc;
    for (int i = 0; i < NREQ; i++) begin
      drive(i, 1'b1, 8 + i, 32'hA000 + 32'(i));
      nxt_addr[i] = AW'(16 + i);
      nxt_data[i] = 32'hB000 + 32'(i);
    end
    rearm = '1;
    for (int i = 0; i < NREQ; i++) expect_w(c + 1 + i, i, 8 + i, 32'hA000 + 32'(i), "rr1");
    for (int i = 0; i < NREQ; i++) expect_w(c + 5 + i, i, 16 + i, 32'hB000 + 32'(i), "rr2");
    repeat (10) step();
    chk("bank11", 64'(bank[11]), 64'(32'hA003));
    chk("bank19", 64'(bank[19]), 64'(32'hB003));

    // Write to register 0 is acknowledged but suppressed.
    do_reset();
    drive(1, 1'b1, 0, 32'h1234);
    expect_w(cyc + 1, 1, 0, 32'h1234, "zero");
    repeat (3) step();
    chk("bank0", 64'(bank[0]), 64'(0));

    // Freeze raised during requester 0's grant with 1 and 3 pending.
    do_reset();
    c = cyc;
    drive(0, 1'b1, 2, 32'h0F0);
    drive(1, 1'b1, 3, 32'h1F1);
    drive(3, 1'b1, 4, 32'h3F3);
    expect_w(c + 1, 0, 2, 32'h0F0, "frz0");
    expect_w(c + 5, 1, 3, 32'h1F1, "frz1");
    expect_w(c + 6, 3, 4, 32'h3F3, "frz3");
    step();
    bus.freeze = 1'b1;
    repeat (3) step();
    bus.freeze = 1'b0;
    repeat (3) step();
    chk("bank2", 64'(bank[2]), 64'(32'h0F0));

    // One requester holding req: granted every other cycle.
    do_reset();
    c = cyc;
    hold[0] = 1'b1;
    drive(0, 1'b1, 3, 32'h55);
    expect_w(c + 1, 0, 3, 32'h55, "b2b_a");
    expect_w(c + 3, 0, 3, 32'h55, "b2b_b");
    expect_w(c + 5, 0, 3, 32'h55, "b2b_c");
    repeat (5) step();
    bus.req[0] = 1'b0;
    hold[0]    = 1'b0;
    repeat (2) step();

    // Reset in the middle of a write to register 5.
    do_reset();
    drive(2, 1'b1, 5, 32'hCAFE0005);
    expect_w(cyc + 1, 2, 5, 32'hCAFE0005, "pre_clr");
    step();
    #4;
    clr = 1'b1;
    #1;
    chk("mid_gnt",  64'(bus.gnt),       64'(0));
    chk("mid_en",   64'(bus.reg_in_en), 64'(0));
    chk("mid_d",    64'(bus.reg_d),     64'(0));
    chk("mid_busy", 64'(bus.busy),      64'(0));
    step();
    chk("bank5", 64'(bank[5]), 64'(0));
    clr = 1'b0;
    drive(3, 1'b1, 9,  32'h3333);
    drive(1, 1'b1, 10, 32'h1111);
    expect_w(cyc + 1, 1, 10, 32'h1111, "post_clr1");
    expect_w(cyc + 2, 3, 9,  32'h3333, "post_clr3");
    repeat (3) step();

    chk("sb_empty", 64'(sbq.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
